// File: rtl/rf_wr_port_scheduler.sv
// rf_wr_port_scheduler
//
// Write-side front end for the 40-entry, 3-write-port register file.
// Each of three producers (ALU, LSU, issue/init) feeds a small FIFO. The
// FIFO for channel N drives register-file write port N. In any one cycle,
// no two ports write the same word. When heads collide, the lower channel
// index wins and the losers retry. Requests that target a word >= 40 are
// dropped, and addr_err is raised for them.
//
// Handshake: a request transfers on a rising edge when reqN_valid and
// reqN_ready are both high. reqN_ready comes only from the registered FIFO
// count, so a full FIFO refuses a request even if it pops in the same
// cycle. reqN_ready is low while rst is high.
//
// Optional feature, selected by the macro RF_WR_BYPASS_EN:
//   defined   - A valid-address request that arrives at an empty FIFO
//               competes for its port in the same cycle. If it wins, wrN_en
//               rises one cycle after acceptance. If it loses, it is
//               enqueued.
//   undefined - Every request passes through the FIFO. The minimum latency
//               from acceptance to wrN_en is two cycles.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake, channel N (N = 0..2)
//   reqN_addr, reqN_data     target word address and write data
//   wrN_en/addr/data         registered register-file write port N
//   addr_err                 one-cycle pulse: an accepted request had addr >= 40
//   idle                     all FIFOs empty and no write enable high
module rf_wr_port_scheduler #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req2_valid,
  output logic             req2_ready,
  input  logic [5:0]       req2_addr,
  input  logic [WIDTH-1:0] req2_data,
  output logic             wr0_en,
  output logic [5:0]       wr0_addr,
  output logic [WIDTH-1:0] wr0_data,
  output logic             wr1_en,
  output logic [5:0]       wr1_addr,
  output logic [WIDTH-1:0] wr1_data,
  output logic             wr2_en,
  output logic [5:0]       wr2_addr,
  output logic [WIDTH-1:0] wr2_data,
  output logic             addr_err,
  output logic             idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [5:0]    NUM_WORDS = 6'd40;

  // Channel-indexed views of the flat port list
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [5:0]       req_addr [3];
  logic [WIDTH-1:0] req_data [3];

  assign req_valid   = {req2_valid, req1_valid, req0_valid};
  assign req_addr[0] = req0_addr;
  assign req_addr[1] = req1_addr;
  assign req_addr[2] = req2_addr;
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;
  assign req_data[2] = req2_data;
  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];
  assign req2_ready  = req_ready[2];

  // FIFO storage and bookkeeping
  logic [5:0]       mem_addr [3][DEPTH];
  logic [WIDTH-1:0] mem_data [3][DEPTH];
  logic [PW-1:0]    rd_ptr   [3];
  logic [PW-1:0]    wr_ptr   [3];
  logic [CW-1:0]    count    [3];

  // Per-cycle selection signals
  logic [2:0]       accept;
  logic [2:0]       addr_ok;
  logic [2:0]       nonempty;
  logic [2:0]       bypass;
  logic [2:0]       head_valid;
  logic [5:0]       head_addr [3];
  logic [WIDTH-1:0] head_data [3];
  logic [2:0]       cand;
  logic [2:0]       push;
  logic [2:0]       pop;

  // Registered write ports
  logic [2:0]       wr_en;
  logic [5:0]       wr_addr_q [3];
  logic [WIDTH-1:0] wr_data_q [3];

  always_comb begin
    req_ready  = '0;
    accept     = '0;
    addr_ok    = '0;
    nonempty   = '0;
    bypass     = '0;
    head_valid = '0;
    cand       = '0;
    push       = '0;
    pop        = '0;
    for (int n = 0; n < 3; n++) begin
      head_addr[n] = '0;
      head_data[n] = '0;
    end

    for (int n = 0; n < 3; n++) begin
      req_ready[n] = ~rst & (count[n] < DEPTH_C);
      accept[n]    = req_valid[n] & req_ready[n];
      addr_ok[n]   = req_addr[n] < NUM_WORDS;
      nonempty[n]  = count[n] != '0;
`ifdef RF_WR_BYPASS_EN
      bypass[n]    = accept[n] & addr_ok[n] & ~nonempty[n];
`else
      bypass[n]    = 1'b0;
`endif
      head_valid[n] = nonempty[n] | bypass[n];
      // When the FIFO is empty, the incoming request is the head. This only
      // matters when the request can bypass.
      head_addr[n]  = nonempty[n] ? mem_addr[n][rd_ptr[n]] : req_addr[n];
      head_data[n]  = nonempty[n] ? mem_data[n][rd_ptr[n]] : req_data[n];
    end

    // Fixed priority. A head yields to any lower channel that is issuing
    // to the same word in this cycle.
    cand[0] = head_valid[0];
    cand[1] = head_valid[1] & ~(cand[0] & (head_addr[1] == head_addr[0]));
    cand[2] = head_valid[2] & ~(cand[0] & (head_addr[2] == head_addr[0]))
                            & ~(cand[1] & (head_addr[2] == head_addr[1]));

    for (int n = 0; n < 3; n++) begin
      // A bypassed request that wins is issued directly and never stored.
      push[n] = accept[n] & addr_ok[n] & ~(bypass[n] & cand[n]);
      pop[n]  = cand[n] & nonempty[n];
    end
  end

  // FIFO payload storage has no reset. Only the pointers and counts give it
  // meaning.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (!rst && push[n]) begin
        mem_addr[n][wr_ptr[n]] <= req_addr[n];
        mem_data[n][wr_ptr[n]] <= req_data[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 3; n++) begin
        rd_ptr[n]    <= '0;
        wr_ptr[n]    <= '0;
        count[n]     <= '0;
        wr_addr_q[n] <= '0;
        wr_data_q[n] <= '0;
      end
      wr_en    <= '0;
      addr_err <= 1'b0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        // DEPTH is a power of two, so pointer overflow wraps for free.
        if (push[n]) wr_ptr[n] <= wr_ptr[n] + PW'(1);
        if (pop[n])  rd_ptr[n] <= rd_ptr[n] + PW'(1);
        count[n] <= count[n] + CW'(push[n]) - CW'(pop[n]);
        if (cand[n]) begin
          wr_addr_q[n] <= head_addr[n];
          wr_data_q[n] <= head_data[n];
        end
      end
      wr_en    <= cand;
      addr_err <= |(accept & ~addr_ok);
    end
  end

  assign wr0_en   = wr_en[0];
  assign wr1_en   = wr_en[1];
  assign wr2_en   = wr_en[2];
  assign wr0_addr = wr_addr_q[0];
  assign wr1_addr = wr_addr_q[1];
  assign wr2_addr = wr_addr_q[2];
  assign wr0_data = wr_data_q[0];
  assign wr1_data = wr_data_q[1];
  assign wr2_data = wr_data_q[2];

  assign idle = (count[0] == '0) && (count[1] == '0) && (count[2] == '0) && (wr_en == '0);

endmodule

// File: tb/tb_rf_wr_port_scheduler.sv
// tb_rf_wr_port_scheduler
//
// Drives directed and random requests into rf_wr_port_scheduler. A
// queue-based reference model predicts ready, the write ports, addr_err
// and idle. Each cycle the bench drives inputs at the falling edge and
// checks outputs 1 time unit later.
module tb_rf_wr_port_scheduler;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  typedef logic [WIDTH+5:0] ent_t;

  // Clock and DUT signals
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             req0_valid, req1_valid, req2_valid;
  logic             req0_ready, req1_ready, req2_ready;
  logic [5:0]       req0_addr, req1_addr, req2_addr;
  logic [WIDTH-1:0] req0_data, req1_data, req2_data;
  logic             wr0_en, wr1_en, wr2_en;
  logic [5:0]       wr0_addr, wr1_addr, wr2_addr;
  logic [WIDTH-1:0] wr0_data, wr1_data, wr2_data;
  logic             addr_err;
  logic             idle;

  rf_wr_port_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .req2_valid(req2_valid), .req2_ready(req2_ready), .req2_addr(req2_addr), .req2_data(req2_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
    .addr_err(addr_err), .idle(idle)
  );

  // Stimulus for the current cycle
  logic             in_rst;
  logic [2:0]       in_v;
  logic [5:0]       in_a [3];
  logic [WIDTH-1:0] in_d [3];

  // Reference model: one queue of {addr, data} per channel, plus the
  // expected registered outputs
  ent_t             q0[$], q1[$], q2[$];
  logic [2:0]       exp_en;
  logic [5:0]       exp_addr [3];
  logic [WIDTH-1:0] exp_data [3];
  logic             exp_err;
  logic             do_check;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int n);
    case (n)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ent_t qhead(input int n);
    case (n)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int n);
    case (n)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(input int n, input ent_t e);
    case (n)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Advance the model across one rising edge with the current stimulus.
  task automatic model_step();
    logic [2:0]       acc, ok, hv, byp, win;
    logic [5:0]       ha [3];
    logic [WIDTH-1:0] hd [3];
    if (in_rst) begin
      q0.delete(); q1.delete(); q2.delete();
      exp_en  = '0;
      exp_err = 1'b0;
      for (int n = 0; n < 3; n++) begin
        exp_addr[n] = '0;
        exp_data[n] = '0;
      end
      return;
    end
    for (int n = 0; n < 3; n++) begin
      acc[n] = in_v[n] && (qsize(n) < DEPTH);
      ok[n]  = in_a[n] < 6'd40;
      hv[n]  = qsize(n) > 0;
      byp[n] = 1'b0;
      ha[n]  = '0;
      hd[n]  = '0;
      if (hv[n]) {ha[n], hd[n]} = qhead(n);
`ifdef RF_WR_BYPASS_EN
      if (!hv[n] && acc[n] && ok[n]) begin
        hv[n] = 1'b1; byp[n] = 1'b1; ha[n] = in_a[n]; hd[n] = in_d[n];
      end
`endif
    end
    // A head issues unless a lower channel issues to the same word.
    for (int n = 0; n < 3; n++) begin
      win[n] = hv[n];
      for (int m = 0; m < n; m++)
        if (win[m] && ha[m] == ha[n]) win[n] = 1'b0;
    end
    for (int n = 0; n < 3; n++) begin
      if (win[n] && !byp[n]) qpop(n);
      if (acc[n] && ok[n] && !(byp[n] && win[n])) qpush(n, {in_a[n], in_d[n]});
      exp_en[n] = win[n];
      if (win[n]) begin
        exp_addr[n] = ha[n];
        exp_data[n] = hd[n];
      end
    end
    exp_err = |(acc & ~ok);
  endtask

  // One cycle: apply inputs, check outputs against the model, advance.
  task automatic tick();
    logic [5:0]       a_got [3];
    logic [WIDTH-1:0] d_got [3];
    logic [2:0]       en_got, rdy_got;
    logic             exp_idle;
    rst        = in_rst;
    req0_valid = in_v[0]; req0_addr = in_a[0]; req0_data = in_d[0];
    req1_valid = in_v[1]; req1_addr = in_a[1]; req1_data = in_d[1];
    req2_valid = in_v[2]; req2_addr = in_a[2]; req2_data = in_d[2];
    #1;
    if (do_check) begin
      en_got  = {wr2_en, wr1_en, wr0_en};
      rdy_got = {req2_ready, req1_ready, req0_ready};
      a_got[0] = wr0_addr; a_got[1] = wr1_addr; a_got[2] = wr2_addr;
      d_got[0] = wr0_data; d_got[1] = wr1_data; d_got[2] = wr2_data;
      for (int n = 0; n < 3; n++) begin
        check_eq($sformatf("ready%0d", n), 64'(rdy_got[n]),
                 64'(!in_rst && qsize(n) < DEPTH));
        check_eq($sformatf("wr%0d_en", n), 64'(en_got[n]), 64'(exp_en[n]));
        check_eq($sformatf("wr%0d_addr", n), 64'(a_got[n]), 64'(exp_addr[n]));
        check_eq($sformatf("wr%0d_data", n), 64'(d_got[n]), 64'(exp_data[n]));
      end
      check_eq("addr_err", 64'(addr_err), 64'(exp_err));
      exp_idle = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) && (exp_en == '0);
      check_eq("idle", 64'(idle), 64'(exp_idle));
      check_eq("dup_addr", 64'((wr0_en && wr1_en && wr0_addr == wr1_addr) ||
                               (wr0_en && wr2_en && wr0_addr == wr2_addr) ||
                               (wr1_en && wr2_en && wr1_addr == wr2_addr)), 64'd0);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    in_rst = 1'b0;
    in_v   = '0;
    for (int n = 0; n < 3; n++) begin
      in_a[n] = '0;
      in_d[n] = '0;
    end
  endtask

  task automatic set_req(input int n, input logic [5:0] a, input logic [WIDTH-1:0] d);
    in_v[n] = 1'b1;
    in_a[n] = a;
    in_d[n] = d;
  endtask

  task automatic do_reset(input int cycles);
    set_idle();
    in_rst = 1'b1;
    repeat (cycles) tick();
    in_rst = 1'b0;
  endtask

  initial begin
    do_check = 1'b0;
    set_idle();
    @(negedge clk);
    do_reset(1);
    do_check = 1'b1;
    do_reset(2);
    repeat (2) tick();

    // Single write on channel 0
    set_idle(); set_req(0, 6'd5, 64'hA5); tick();
    set_idle(); repeat (4) tick();

    // Three distinct addresses in the same cycle
    set_idle(); set_req(0, 6'd3, 64'h33); set_req(1, 6'd7, 64'h77); set_req(2, 6'd9, 64'h99); tick();
    set_idle(); repeat (4) tick();

    // All three channels target word 12
    set_idle(); set_req(0, 6'd12, 64'd1); set_req(1, 6'd12, 64'd2); set_req(2, 6'd12, 64'd3); tick();
    set_idle(); repeat (5) tick();

    // Backpressure: channel 0 occupies word 20 while channel 1 piles up behind it
    for (int i = 0; i < 10; i++) begin
      set_idle(); set_req(0, 6'd20, 64'(100 + i)); set_req(1, 6'd20, 64'(200 + i)); tick();
    end
    set_idle(); repeat (8) tick();

    // Out-of-range addresses on channel 2
    set_idle(); set_req(2, 6'd40, 64'hDEAD); tick();
    set_idle(); set_req(2, 6'd63, 64'hBEEF); tick();
    set_idle(); set_req(0, 6'd45, 64'h1); set_req(2, 6'd50, 64'h2); tick();
    set_idle(); repeat (3) tick();

    // Fill channels behind conflicts, then reset mid-operation
    for (int i = 0; i < 4; i++) begin
      set_idle(); set_req(0, 6'd30, 64'(i)); set_req(1, 6'd30, 64'(i + 10)); set_req(2, 6'd30, 64'(i + 20)); tick();
    end
    do_reset(1);
    set_idle(); repeat (4) tick();

    // Random traffic, biased toward address collisions
    for (int i = 0; i < 3000; i++) begin
      set_idle();
      in_rst = ($urandom_range(0, 299) == 0);
      for (int n = 0; n < 3; n++) begin
        if ($urandom_range(0, 99) < 60) begin
          if ($urandom_range(0, 19) == 0)
            set_req(n, 6'($urandom_range(40, 63)), {$urandom, $urandom});
          else
            set_req(n, 6'($urandom_range(0, 7)), {$urandom, $urandom});
        end
      end
      tick();
    end
    set_idle(); repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
